// File: rtl/sisc_pkg.sv
// Shared widths and fetch-state encoding for the sisc fetch slice.
package sisc_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/sisc_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, core valid/ready and branch redirect.
interface sisc_fetch_if #(
  parameter int unsigned ADDR_W = sisc_pkg::ADDR_W,
  parameter int unsigned DATA_W = sisc_pkg::DATA_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;

  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc,
    input  imem_ack, imem_rdata, ir_ready, br_taken, br_addr
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir, ir_pc,
    output imem_ack, imem_rdata, ir_ready, br_taken, br_addr
  );
endinterface

// File: rtl/sisc_fetch_q.sv
// Small {pc, instr} FIFO between instruction memory and the core; flush wins over push/pop.
module sisc_fetch_q #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_f,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic [DATA_W-1:0]          push_instr,
  output logic                       valid,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [DATA_W-1:0]          head_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign valid      = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
endmodule

// File: rtl/sisc_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight, redirects on branch.
module sisc_fetch #(
  parameter int unsigned ADDR_W = sisc_pkg::ADDR_W,
  parameter int unsigned DATA_W = sisc_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input logic        clk,
  input logic        rst_f,
  sisc_fetch_if.master bus
);
  import sisc_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_inc;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              space;
  int                count_after;

  // An outstanding request reserves a slot, so a response always finds room.
  always_comb begin
    fpc_inc     = fpc + 1'b1;
    space       = (int'(count) + int'(state != IDLE)) < int'(DEPTH);
    pop         = bus.ir_valid && bus.ir_ready && !bus.br_taken;
    push        = (state == WAIT) && bus.imem_ack && !bus.br_taken;
    count_after = int'(count) + int'(push) - int'(pop);
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= IDLE;
      fpc           <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.br_taken) begin
            fpc           <= bus.br_addr;
            state         <= WAIT;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= bus.br_addr;
          end else if (space) begin
            state         <= WAIT;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fpc;
          end
        end
        WAIT: begin
          if (bus.br_taken) begin
            fpc <= bus.br_addr;
            if (bus.imem_ack) begin
              state        <= IDLE;
              bus.imem_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (bus.imem_ack) begin
            fpc <= fpc_inc;
            if (count_after < int'(DEPTH)) begin
              bus.imem_addr <= fpc_inc;
            end else begin
              state        <= IDLE;
              bus.imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.br_taken) begin
            fpc <= bus.br_addr;
          end
          if (bus.imem_ack) begin
            state        <= IDLE;
            bus.imem_req <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.imem_req <= 1'b0;
        end
      endcase
    end
  end

  sisc_fetch_q #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_q (
    .clk       (clk),
    .rst_f     (rst_f),
    .flush     (bus.br_taken),
    .push      (push),
    .pop       (pop),
    .push_pc   (fpc),
    .push_instr(bus.imem_rdata),
    .valid     (bus.ir_valid),
    .head_pc   (bus.ir_pc),
    .head_instr(bus.ir),
    .count     (count)
  );
endmodule

// File: doc/sisc_fetch.md
# sisc_fetch

Instruction fetch stage that sits directly upstream of the `sisc` core and produces the 32-bit `ir` word it decodes. The block owns the fetch PC and issues single-outstanding read requests to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small queue, and the queue is presented to the core through a valid/ready interface. A branch redirect from the core flushes the queue and any in-flight response, then restarts fetch at the branch target.

## Interface
- `ADDR_W`, 16, fetch PC and instruction-memory address width (word address)
- `DATA_W`, 32, instruction width
- `DEPTH`, 2, instruction queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_f`  in  1  reset, asynchronous assert, active-low; the only reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  ADDR_W  request address; stable while `imem_req` is high
- `imem_ack`  in  1  request accepted; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  DATA_W  instruction word
- `ir_valid`  out  1  queue head is valid
- `ir`  out  DATA_W  queue head instruction
- `ir_pc`  out  ADDR_W  PC of queue head
- `ir_ready`  in  1  core consumes head when `ir_valid && ir_ready`
- `br_taken`  in  1  redirect strobe (one cycle)
- `br_addr`  in  ADDR_W  redirect target

## Operation
- States: `IDLE` (no request), `WAIT` (request outstanding), `DROP` (request outstanding, response to be discarded).
- Space condition: `count + (state != IDLE) < DEPTH`, evaluated on registered values.
- `IDLE`: if space, assert `imem_req` with `imem_addr = fpc` and go to `WAIT`.
- `WAIT` and `imem_ack`: push {`fpc`, `imem_rdata`}; `fpc <= fpc + 1` (wraps modulo 2^ADDR_W); go to `WAIT` if space remains after the push, else `IDLE`.
- `br_taken` (highest priority):
  - Queue cleared; `fpc <= br_addr`.
  - Any pop in the same cycle is ignored.
  - In `WAIT` without ack: go to `DROP`. `imem_req` stays high with the old address until ack, per the handshake rule.
  - In `WAIT` with ack: response discarded; go to `IDLE`.
  - In `DROP`: stay in `DROP` (or go to `IDLE` on ack); new target latched.
- `DROP` and `imem_ack`: data discarded; go to `IDLE`.
- Pop: `ir_valid && ir_ready && !br_taken` removes the head.
- Push and pop may occur in the same cycle. By the space rule, a push never targets a full queue.
- `imem_req` is never deasserted before ack. `imem_addr` never changes while `imem_req` is high.

## Timing
- Reset values:
  - `imem_req=0`, `imem_addr=0`, `ir_valid=0`, `ir=0`, `ir_pc=0`
  - `fpc=0`, `count=0`, state `IDLE`
- First request: `imem_req` rises in the first cycle after `rst_f` deasserts.
- Latency: request with ack in cycle N → `ir_valid` in cycle N+1.
- Zero-wait memory streams one instruction per cycle only if `DEPTH` ≥ 2 and the core pops every cycle. Otherwise fetch throttles on the space rule.
- Redirect in cycle N, no request outstanding:
  - `imem_req` with `br_addr` in cycle N+1.
  - First target instruction valid in N+2 at best.
- `ir_valid` falls in the cycle after `br_taken`.
- Reset asserted mid-transaction: all state clears immediately. The memory must discard the abandoned request.

## Structure
- Package `sisc_pkg`: `ADDR_W`/`DATA_W` defaults and the fetch-state enum (`IDLE`, `WAIT`, `DROP`).
- Sub-module `sisc_fetch_q`: `DEPTH`-entry synchronous FIFO of {pc, instr} with flush, push, pop and count. The FSM and `fpc` live in the top.

## Test plan
- Reset, zero-wait memory returning `32'h1000_0000 + addr`, `ir_ready=1`:
  - `imem_addr` 0,1,2,…
  - `ir`/`ir_pc` pairs (`32'h10000000`, 0), (`32'h10000001`, 1) from cycle 2.
  - One instruction per cycle.
- `ir_ready=0` for 10 cycles:
  - Exactly `DEPTH` pushes, then `imem_req` stays low.
  - Release `ir_ready` → order is preserved and no word is lost.
- Memory acks 3 cycles late; `br_taken` with `br_addr=16'h0040` while in `WAIT`:
  - `imem_addr` holds the old value until ack, and that word never appears on `ir`.
  - Next request is to `16'h0040`.
- `br_taken` in the same cycle as `imem_ack` and `ir_ready`:
  - Acked word dropped, queue empty next cycle.
  - Next `ir_pc` is the target.
- `fpc` starting at `16'hFFFF`: after ack, next `imem_addr` is `16'h0000`.
- Assert `rst_f=0` while `imem_req` is high: all outputs are 0 asynchronously. After release, fetch restarts at 0.
